// File: rtl/sha256_msg_ctrl.sv
// SHA-256 message controller: packs 32-bit words into 512-bit blocks, pads, and sequences an external compression core.
// Optional macro SHA256_DOUBLE_EN adds a second pass that hashes the first digest (SHA256(SHA256(msg))).
module sha256_msg_ctrl #(
  parameter int LEN_W = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [31:0]  s_data,
  input  logic         s_valid,
  output logic         s_ready,
  input  logic         s_last,
  input  logic [2:0]   s_nbytes,
  output logic [255:0] blk_H,
  output logic [511:0] blk_M,
  output logic         blk_start,
  input  logic         blk_done,
  input  logic [255:0] blk_H_new,
  output logic [255:0] digest,
  output logic         digest_valid,
  output logic         busy,
  output logic [2:0]   dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE, S_FILL, S_PAD, S_XPAD, S_START, S_WAIT, S_DONE
  } state_t;

  localparam int CNT_W = LEN_W - 3;
  localparam logic [255:0] H_INIT =
    256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;

  state_t           state_q, state_d;
  logic [255:0]     blk_h_q, blk_h_d;
  logic [511:0]     blk_m_q, blk_m_d;
  logic [CNT_W-1:0] byte_cnt_q, byte_cnt_d;
  logic [3:0]       word_idx_q, word_idx_d;
  logic [6:0]       pad_pos_q, pad_pos_d;
  logic             xpad_q, xpad_d;
  logic             xpad80_q, xpad80_d;
  logic             fin_q, fin_d;
  logic [255:0]     digest_q, digest_d;
  logic             digest_valid_q, digest_valid_d;
`ifdef SHA256_DOUBLE_EN
  logic             second_q, second_d;
`endif

  logic             accept;
  logic [3:0]       widx;
  logic [2:0]       nb_eff;
  logic [CNT_W-1:0] cnt_base;
  logic [63:0]      bit_len;

  // s_valid/s_ready: a word transfers on a rising edge where both are high; s_ready never depends on s_valid.
  assign accept = s_valid && s_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= S_IDLE;
      blk_h_q        <= '0;
      blk_m_q        <= '0;
      byte_cnt_q     <= '0;
      word_idx_q     <= '0;
      pad_pos_q      <= '0;
      xpad_q         <= 1'b0;
      xpad80_q       <= 1'b0;
      fin_q          <= 1'b0;
      digest_q       <= '0;
      digest_valid_q <= 1'b0;
`ifdef SHA256_DOUBLE_EN
      second_q       <= 1'b0;
`endif
    end else begin
      state_q        <= state_d;
      blk_h_q        <= blk_h_d;
      blk_m_q        <= blk_m_d;
      byte_cnt_q     <= byte_cnt_d;
      word_idx_q     <= word_idx_d;
      pad_pos_q      <= pad_pos_d;
      xpad_q         <= xpad_d;
      xpad80_q       <= xpad80_d;
      fin_q          <= fin_d;
      digest_q       <= digest_d;
      digest_valid_q <= digest_valid_d;
`ifdef SHA256_DOUBLE_EN
      second_q       <= second_d;
`endif
    end
  end

  always_comb begin
    state_d        = state_q;
    blk_h_d        = blk_h_q;
    blk_m_d        = blk_m_q;
    byte_cnt_d     = byte_cnt_q;
    word_idx_d     = word_idx_q;
    pad_pos_d      = pad_pos_q;
    xpad_d         = xpad_q;
    xpad80_d       = xpad80_q;
    fin_d          = fin_q;
    digest_d       = digest_q;
    digest_valid_d = 1'b0;
`ifdef SHA256_DOUBLE_EN
    second_d       = second_q;
`endif
    widx     = (state_q == S_IDLE) ? 4'd0 : word_idx_q;
    nb_eff   = !s_last ? 3'd4 : (s_nbytes > 3'd4) ? 3'd4 : s_nbytes;
    cnt_base = (state_q == S_IDLE) ? '0 : byte_cnt_q;
    bit_len  = 64'({byte_cnt_q, 3'b000});

    case (state_q)
      S_IDLE, S_FILL: begin
        if (accept) begin
          if (state_q == S_IDLE) begin
            blk_h_d  = H_INIT;
            xpad_d   = 1'b0;
            xpad80_d = 1'b0;
            fin_d    = 1'b0;
`ifdef SHA256_DOUBLE_EN
            second_d = 1'b0;
`endif
          end
          blk_m_d[{4'd15 - widx, 5'd0} +: 32] = s_data;
          byte_cnt_d = cnt_base + CNT_W'(nb_eff);
          word_idx_d = widx + 4'd1;
          pad_pos_d  = {1'b0, widx, 2'b00} + {4'b0000, nb_eff};
          if (s_last)             state_d = S_PAD;
          else if (widx == 4'd15) state_d = S_START;
          else                    state_d = S_FILL;
        end
      end
      S_PAD: begin
        // pad_pos_q == 64 means the block is full: leave it intact and carry 0x80 into the extra block.
        for (int i = 0; i < 64; i++) begin
          if (7'(i) == pad_pos_q)     blk_m_d[8*(63-i) +: 8] = 8'h80;
          else if (7'(i) > pad_pos_q) blk_m_d[8*(63-i) +: 8] = 8'h00;
        end
        if (pad_pos_q <= 7'd55) begin
          blk_m_d[63:0] = bit_len;
          fin_d         = 1'b1;
        end else begin
          xpad_d   = 1'b1;
          xpad80_d = (pad_pos_q == 7'd64);
        end
        state_d = S_START;
      end
      S_XPAD: begin
        blk_m_d  = {(xpad80_q ? 8'h80 : 8'h00), 440'd0, bit_len};
        xpad_d   = 1'b0;
        xpad80_d = 1'b0;
        fin_d    = 1'b1;
        state_d  = S_START;
      end
      S_START: state_d = S_WAIT;
      S_WAIT: begin
        if (blk_done) begin
          blk_h_d = blk_H_new;
          if (fin_q)       state_d = S_DONE;
          else if (xpad_q) state_d = S_XPAD;
          else             state_d = S_FILL;
        end
      end
      S_DONE: begin
`ifdef SHA256_DOUBLE_EN
        if (!second_q) begin
          blk_h_d  = H_INIT;
          blk_m_d  = {blk_h_q, 8'h80, 184'd0, 64'd256};
          second_d = 1'b1;
          state_d  = S_START;
        end else begin
          digest_d       = blk_h_q;
          digest_valid_d = 1'b1;
          state_d        = S_IDLE;
        end
`else
        digest_d       = blk_h_q;
        digest_valid_d = 1'b1;
        state_d        = S_IDLE;
`endif
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    s_ready      = !rst && (state_q == S_IDLE || state_q == S_FILL);
    busy         = !rst && (state_q != S_IDLE);
    blk_start    = !rst && (state_q == S_START);
    digest_valid = !rst && digest_valid_q;
  end

  assign blk_H     = blk_h_q;
  assign blk_M     = blk_m_q;
  assign digest    = digest_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_sha256_msg_ctrl.sv
// Bench for sha256_msg_ctrl: drives words, emulates the compression core with a reference SHA-256 round function.
// Honors SHA256_DOUBLE_EN to select double-hash expectations.
module tb_sha256_msg_ctrl;

  localparam logic [255:0] IV =
    256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;
`ifdef SHA256_DOUBLE_EN
  localparam int DBL = 1;
  localparam logic [255:0] EXP_ABC = 256'h4f8b42c22dd3729b519ba6f68d2da7cc5b2d606d05daed5ad5128cc03e6c6358;
`else
  localparam int DBL = 0;
  localparam logic [255:0] EXP_ABC = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
`endif
  localparam logic [255:0] SHA_EMPTY = 256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;
  localparam logic [255:0] SHA_56B   = 256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;

  localparam logic [31:0] K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

  logic         clk, rst;
  logic [31:0]  s_data;
  logic         s_valid, s_ready, s_last;
  logic [2:0]   s_nbytes;
  logic [255:0] blk_H, blk_H_new, digest;
  logic [511:0] blk_M;
  logic         blk_start, blk_done, digest_valid, busy;
  logic [2:0]   dbg_state;

  sha256_msg_ctrl dut (
    .clk(clk), .rst(rst), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .s_last(s_last), .s_nbytes(s_nbytes), .blk_H(blk_H), .blk_M(blk_M),
    .blk_start(blk_start), .blk_done(blk_done), .blk_H_new(blk_H_new),
    .digest(digest), .digest_valid(digest_valid), .busy(busy), .dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass = 0;
  int n_starts = 0;
  int n_dv = 0;
  int stable_bad = 0;
  int ready_bad = 0;
  int lat_cfg = 3;
  logic resp_busy = 1'b0;
  logic resp_abort = 1'b0;
  string cur_name = "none";
  logic [255:0] exp_q[$];
  logic [31:0] msg_w [16];

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  function automatic logic [31:0] ror(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [255:0] sha_compress(input logic [255:0] hin, input logic [511:0] m);
    logic [31:0] w [64];
    logic [31:0] a, b, c, d, e, f, g, h, t1, t2, s0, s1;
    for (int t = 0; t < 16; t++) w[t] = m[511-32*t -: 32];
    for (int t = 16; t < 64; t++) begin
      s0 = ror(w[t-15], 7) ^ ror(w[t-15], 18) ^ (w[t-15] >> 3);
      s1 = ror(w[t-2], 17) ^ ror(w[t-2], 19) ^ (w[t-2] >> 10);
      w[t] = w[t-16] + s0 + w[t-7] + s1;
    end
    {a, b, c, d, e, f, g, h} = hin;
    for (int t = 0; t < 64; t++) begin
      t1 = h + (ror(e, 6) ^ ror(e, 11) ^ ror(e, 25)) + ((e & f) ^ (~e & g)) + K[t] + w[t];
      t2 = (ror(a, 2) ^ ror(a, 13) ^ ror(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
      h = g; g = f; f = e; e = d + t1; d = c; c = b; b = a; a = t1 + t2;
    end
    return {hin[255:224] + a, hin[223:192] + b, hin[191:160] + c, hin[159:128] + d,
            hin[127:96] + e, hin[95:64] + f, hin[63:32] + g, hin[31:0] + h};
  endfunction

  function automatic logic [255:0] dbl(input logic [255:0] d);
`ifdef SHA256_DOUBLE_EN
    return sha_compress(IV, {d, 8'h80, 184'd0, 64'd256});
`else
    return d;
`endif
  endfunction

  // compression-core emulator: sees blk_start, answers lat_cfg cycles later with a one-cycle blk_done
  logic [255:0] h_cap, res;
  logic [511:0] m_cap;
  initial begin
    blk_done = 1'b0;
    blk_H_new = '0;
    forever begin
      @(negedge clk);
      blk_done = 1'b0;
      if (blk_start) begin
        n_starts++;
        h_cap = blk_H;
        m_cap = blk_M;
        res = sha_compress(h_cap, m_cap);
        resp_busy = 1'b1;
        resp_abort = 1'b0;
        for (int i = 0; i < lat_cfg; i++) begin
          @(negedge clk);
          if (rst) resp_abort = 1'b1;
          if (!resp_abort && (blk_H !== h_cap || blk_M !== m_cap)) stable_bad++;
        end
        blk_done = 1'b1;
        blk_H_new = res;
        resp_busy = 1'b0;
      end
    end
  end

  // scoreboard
  always @(negedge clk) begin
    if (resp_busy && !resp_abort && s_ready) ready_bad++;
    if (digest_valid) begin
      n_dv++;
      if (exp_q.size() == 0) check({cur_name, "_unexpected_dv"}, 1, 0);
      else check({cur_name, "_digest"}, digest, exp_q.pop_front());
    end
  end

  // driver
  task automatic send_word(input logic [31:0] d, input logic last, input logic [2:0] nb, input int max_gap);
    int g, t;
    g = (max_gap > 0) ? $urandom_range(max_gap, 0) : 0;
    repeat (g) begin
      @(negedge clk);
      s_valid = 1'b0;
      s_data = $urandom;
      s_last = 1'($urandom_range(1, 0));
    end
    @(negedge clk);
    s_valid = 1'b1;
    s_data = d;
    s_last = last;
    s_nbytes = nb;
    t = 0;
    while (!s_ready && t < 500) begin
      @(negedge clk);
      t++;
    end
    if (t >= 500) check({cur_name, "_ready_timeout"}, 0, 1);
    @(posedge clk);
  endtask

  task automatic run_msg(input string name, input int nw, input logic [2:0] nb,
                         input logic [255:0] exp, input int blocks, input int max_gap, input int lat);
    int s0, d0, cyc, nblk;
    cur_name = name;
    lat_cfg = lat;
    nblk = blocks + DBL;
    s0 = n_starts;
    d0 = n_dv;
    exp_q.push_back(exp);
    for (int i = 0; i < nw; i++)
      send_word(msg_w[i], (i == nw - 1), (i == nw - 1) ? nb : 3'd4, max_gap);
    cyc = 0;
    do begin
      @(negedge clk);
      s_valid = 1'b0;
      cyc++;
    end while (!digest_valid && cyc < 3000);
    check({name, "_latency"}, cyc, nblk * (lat + 2) + 2);
    @(negedge clk);
    check({name, "_starts"}, n_starts - s0, nblk);
    check({name, "_dv_count"}, n_dv - d0, 1);
    repeat (4) @(negedge clk);
    check({name, "_digest_hold"}, digest, exp);
    check({name, "_idle"}, busy, 0);
  endtask

  logic [511:0] mb;
  int t0, d0;
  initial begin
    rst = 1'b1;
    s_valid = 1'b0; s_data = '0; s_last = 1'b0; s_nbytes = '0;
    repeat (3) @(negedge clk);
    check("rst_s_ready", s_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_blk_start", blk_start, 0);
    check("rst_digest_valid", digest_valid, 0);
    check("rst_digest", digest, 0);
    check("rst_blk_H", blk_H, 0);
    check("rst_blk_M", blk_M[511:256], 0);
    rst = 1'b0;
    #1;
    check("post_rst_s_ready", s_ready, 1);

    msg_w[0] = 32'h61626300;
    run_msg("abc", 1, 3'd3, EXP_ABC, 1, 0, 3);

    msg_w[0] = 32'hdeadbeef;
    run_msg("empty", 1, 3'd0, dbl(SHA_EMPTY), 1, 0, 1);

    msg_w = '{32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667, 32'h65666768, 32'h66676869,
              32'h6768696a, 32'h68696a6b, 32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
              32'h6d6e6f70, 32'h6e6f7071, 32'h0, 32'h0};
    run_msg("b56", 14, 3'd4, dbl(SHA_56B), 2, 0, 2);
    run_msg("b56_gaps", 14, 3'd4, dbl(SHA_56B), 2, 3, 3);

    msg_w[0] = 32'h61626300;
    run_msg("abc_gaps", 1, 3'd3, EXP_ABC, 1, 3, 4);

    // 55 bytes: last single-block length; byte 55 of the final word must become 0x80
    mb = '0;
    for (int i = 0; i < 14; i++) begin
      msg_w[i] = $urandom;
      mb[511-32*i -: 32] = msg_w[i];
    end
    mb[71:64] = 8'h80;
    mb[63:0] = 64'd440;
    run_msg("b55", 14, 3'd3, dbl(sha_compress(IV, mb)), 1, 1, 2);

    // 64 bytes: full block, then a fresh block starting with 0x80
    for (int i = 0; i < 16; i++) begin
      msg_w[i] = $urandom;
      mb[511-32*i -: 32] = msg_w[i];
    end
    run_msg("b64", 16, 3'd4,
            dbl(sha_compress(sha_compress(IV, mb), {8'h80, 440'd0, 64'd512})), 2, 1, 3);

    // reset during WAIT of the first block; the late blk_done must be ignored
    cur_name = "rst_wait";
    lat_cfg = 8;
    d0 = n_dv;
    send_word(32'h61626300, 1'b1, 3'd3, 0);
    @(negedge clk);
    s_valid = 1'b0;
    t0 = 0;
    while (!resp_busy && t0 < 100) begin
      @(negedge clk);
      t0++;
    end
    check("rst_wait_reached", resp_busy, 1);
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_wait_digest_clear", digest, 0);
    check("rst_wait_blk_H_clear", blk_H, 0);
    rst = 1'b0;
    t0 = 0;
    while (resp_busy && t0 < 100) begin
      @(negedge clk);
      t0++;
    end
    repeat (3) @(negedge clk);
    check("rst_wait_no_dv", n_dv - d0, 0);
    check("rst_wait_idle", busy, 0);
    msg_w[0] = 32'h61626300;
    run_msg("abc_after_rst", 1, 3'd3, EXP_ABC, 1, 0, 3);

    check("blk_stable_in_wait", stable_bad, 0);
    check("no_ready_while_busy", ready_bad, 0);
    check("scoreboard_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
